// File: rtl/scan_decoder.sv
// One-hot address decoder with direct, scan-up, scan-down and hold modes.
// Outputs are registered; cur_addr always mirrors the internal pointer.
module scan_decoder #(
    parameter int ADDR_WIDTH = 2,
    localparam int NUM_OUT   = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_OUT-1:0]    out,
    output logic                  valid,
    output logic                  wrap,
    output logic [ADDR_WIDTH-1:0] cur_addr,
    output logic                  dbg_state
);

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [NUM_OUT-1:0]      out_q, out_d;
    logic                    valid_q;
    logic                    wrap_q, wrap_d;

    // Pointer arithmetic wraps naturally at the register width, i.e. modulo NUM_OUT.
    always_comb begin
        ptr_d  = ptr_q;
        wrap_d = 1'b0;
        if (load) begin
            ptr_d = addr;
        end else begin
            case (mode)
                MODE_DIRECT: ptr_d = addr;
                MODE_UP: begin
                    ptr_d  = ptr_q + ADDR_WIDTH'(1);
                    wrap_d = (ptr_q == {ADDR_WIDTH{1'b1}});
                end
                MODE_DOWN: begin
                    ptr_d  = ptr_q - ADDR_WIDTH'(1);
                    wrap_d = (ptr_q == '0);
                end
                default: ptr_d = ptr_q;
            endcase
        end
        out_d = NUM_OUT'(1) << ptr_d;
    end

    // Disabled edges hold ptr so a later scan resumes where it stopped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_OFF;
            ptr_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (!enable) begin
            state_q <= ST_OFF;
            out_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= ST_ON;
            ptr_q   <= ptr_d;
            out_q   <= out_d;
            valid_q <= 1'b1;
            wrap_q  <= wrap_d;
        end
    end

    assign out       = out_q;
    assign valid     = valid_q;
    assign wrap      = wrap_q;
    assign cur_addr  = ptr_q;
    assign dbg_state = state_q;

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter ADDR_WIDTH, default 2, SHALL set the address width; legal range 1..6.
REQ-002 Parameter NUM_OUT, fixed at 2**ADDR_WIDTH, SHALL set the one-hot output width.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be asynchronous, active-high reset.
REQ-005 Port enable  input  1  SHALL gate the decoder: 1 = active, 0 = all outputs deasserted.
REQ-006 Port mode  input  2  SHALL select the operation: 00 direct, 01 scan-up, 10 scan-down, 11 hold.
REQ-007 Port load  input  1  SHALL force ptr <= addr for one cycle, overriding mode.
REQ-008 Port addr  input  ADDR_WIDTH  SHALL be the address used in direct mode and on load.
REQ-009 Port out  output  NUM_OUT  SHALL be the registered one-hot decode of ptr.
REQ-010 Port valid  output  1  SHALL be high when out holds a valid one-hot code.
REQ-011 Port wrap  output  1  SHALL be a one-cycle pulse on scan wrap-around.
REQ-012 Port cur_addr  output  ADDR_WIDTH  SHALL be the current ptr value.

Function
REQ-013 The block SHALL hold an internal register ptr[ADDR_WIDTH-1:0] and a two-state FSM: OFF, ON.
REQ-014 FSM SHALL move OFF->ON on a rising edge with enable=1, ON->OFF on a rising edge with enable=0, and otherwise hold its state.
REQ-015 On an edge with enable=0: ptr holds; out <= 0; valid <= 0; wrap <= 0.
REQ-016 On an edge with enable=1 and load=1: ptr <= addr; wrap <= 0; mode ignored.
REQ-017 On an edge with enable=1, load=0, mode=00: ptr <= addr.
REQ-018 On an edge with enable=1, load=0, mode=01: ptr <= ptr+1 modulo NUM_OUT; wrap <= 1 iff old ptr = NUM_OUT-1.
REQ-019 On an edge with enable=1, load=0, mode=10: ptr <= ptr-1 modulo NUM_OUT; wrap <= 1 iff old ptr = 0.
REQ-020 On an edge with enable=1, load=0, mode=11: ptr holds; wrap <= 0.
REQ-021 On every edge with enable=1: out <= one-hot(next ptr), so bit k is 1 iff next ptr = k; valid <= 1.
REQ-022 Latency SHALL be exactly one clock from the inputs sampled to out/valid/cur_addr.
REQ-023 wrap SHALL be 0 in direct mode, in hold mode, on load, and when enable=0.
REQ-024 While valid=1, out SHALL contain exactly one set bit; while valid=0, out SHALL be all zero.
REQ-025 cur_addr SHALL equal ptr at all times, including while enable=0.
REQ-026 When enable returns to 1 after 0, scan SHALL resume from the held ptr, not from 0.
REQ-027 addr SHALL have no effect unless load=1 or mode=00.

Reset
REQ-028 While reset=1: ptr=0, FSM=OFF, out=0, valid=0, wrap=0, cur_addr=0, immediately and independent of clk.
REQ-029 Reset asserted mid-scan SHALL discard ptr; the first enabled edge after release SHALL proceed from ptr=0.
REQ-030 On the first edge after reset release, the design SHALL obey the Function rules with no extra cycles.

Verification
REQ-031 ADDR_WIDTH=2; reset pulse; enable=0 for all 4 addr values -> out=0000, valid=0, wrap=0.
REQ-032 enable=1, mode=00, addr=0,1,2,3 on successive edges -> out=0001,0010,0100,1000 one edge later; valid=1.
REQ-033 load addr=2, then mode=01 for 3 edges -> cur_addr 2,3,0,1; wrap=1 only on the 3->0 edge.
REQ-034 load addr=1, then mode=10 for 3 edges -> cur_addr 1,0,3,2; wrap=1 only on the 0->3 edge.
REQ-035 scan-up to ptr=2, then enable=0 for 2 edges, then enable=1 with mode=01 -> out=0 and cur_addr=2 while disabled; next ptr=3.
REQ-036 Async reset mid-clock at ptr=3 -> all outputs 0 before the next edge; ADDR_WIDTH=3 scan-up from 7 -> ptr 0, wrap=1, out=00000001.
